bitwise_pg_buffer: RTL and testbench

- Registered front-end stage of a parallel-prefix (Brent-Kung style) adder.
- Computes per-bit generate and propagate from operands A and B, and injects carry-in at bit 0.
- Carries a separate (P,G) pair vector through a delay-matching buffer lane, so prefix-tree nodes that skip a level stay aligned with computed nodes.
- All outputs are registered; single clock domain.

---
 rtl/bitwise_pg_buffer.sv | 109 ++++++++++
 tb/tb_bitwise_pg_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_pg_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_pg_buffer
// Purpose  : Registered generate/propagate front end of a parallel-prefix
//            adder, plus a delay-matched (P,G) pass-through buffer lane.
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_pg_buffer #(
  parameter int WIDTH      = 32,
  parameter int CIN_INJECT = 1,
  parameter int BUF_DEPTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out,
  output logic             pg_valid,
  input  logic             buf_valid_in,
  input  logic [WIDTH-1:0] pin,
  input  logic [WIDTH-1:0] gin,
  output logic [WIDTH-1:0] pout,
  output logic [WIDTH-1:0] gout,
  output logic             buf_valid_out
);

  generate
    if (WIDTH < 2 || BUF_DEPTH < 1 || BUF_DEPTH > 4) begin : g_bad_params
      $error("bitwise_pg_buffer: WIDTH must be >= 2 and BUF_DEPTH within 1..4");
    end
  endgenerate

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;

  // Propagate is XOR so the sum stage can reuse it directly.
  generate
    if (CIN_INJECT != 0) begin : g_cin_inject
      always_comb begin
        w_g    = a & b;
        w_p    = a ^ b;
        w_g[0] = cin;
        w_p[0] = 1'b0;
      end
    end else begin : g_cin_compute
      assign w_g = a & b;
      assign w_p = a ^ b;
    end
  endgenerate

  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_p;
  logic             r_pg_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g        <= '0;
      r_p        <= '0;
      r_pg_valid <= 1'b0;
    end else begin
      r_pg_valid <= in_valid;
      if (in_valid) begin
        r_g <= w_g;
        r_p <= w_p;
      end
    end
  end

  assign g_out    = r_g;
  assign p_out    = r_p;
  assign pg_valid = r_pg_valid;

  logic [WIDTH-1:0]     r_pbuf [BUF_DEPTH];
  logic [WIDTH-1:0]     r_gbuf [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_vbuf;

  // Each stage loads only behind a valid token; the valid chain always shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < BUF_DEPTH; k++) begin
        r_pbuf[k] <= '0;
        r_gbuf[k] <= '0;
      end
      r_vbuf <= '0;
    end else begin
      r_vbuf[0] <= buf_valid_in;
      if (buf_valid_in) begin
        r_pbuf[0] <= pin;
        r_gbuf[0] <= gin;
      end
      for (int k = 1; k < BUF_DEPTH; k++) begin
        r_vbuf[k] <= r_vbuf[k-1];
        if (r_vbuf[k-1]) begin
          r_pbuf[k] <= r_pbuf[k-1];
          r_gbuf[k] <= r_gbuf[k-1];
        end
      end
    end
  end

  assign pout          = r_pbuf[BUF_DEPTH-1];
  assign gout          = r_gbuf[BUF_DEPTH-1];
  assign buf_valid_out = r_vbuf[BUF_DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_bitwise_pg_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_pg_buffer
// Purpose  : Scoreboard bench for two bitwise_pg_buffer configurations
//            (carry injected / depth 2, and carry computed / depth 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_pg_buffer;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         buf_valid_in = 1'b0;
  logic [W-1:0] pin = '0;
  logic [W-1:0] gin = '0;

  logic [W-1:0] g1, p1, po1, go1;
  logic         pv1, bv1;
  logic [W-1:0] g0, p0, po0, go0;
  logic         pv0, bv0;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  exp_t q_pg1[$];
  exp_t q_buf1[$];
  exp_t q_pg0[$];
  exp_t q_buf0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitwise_pg_buffer #(.WIDTH(W), .CIN_INJECT(1), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .g_out(g1), .p_out(p1), .pg_valid(pv1),
    .buf_valid_in(buf_valid_in), .pin(pin), .gin(gin),
    .pout(po1), .gout(go1), .buf_valid_out(bv1)
  );

  bitwise_pg_buffer #(.WIDTH(W), .CIN_INJECT(0), .BUF_DEPTH(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .g_out(g0), .p_out(p0), .pg_valid(pv0),
    .buf_valid_in(buf_valid_in), .pin(pin), .gin(gin),
    .pout(po0), .gout(go0), .buf_valid_out(bv0)
  );

  function automatic exp_t pg_model(logic [W-1:0] ma, logic [W-1:0] mb,
                                    logic mc, bit inj, int due);
    exp_t e;
    e.x = ma & mb;
    e.y = ma ^ mb;
    if (inj) begin
      e.x[0] = mc;
      e.y[0] = 1'b0;
    end
    e.due = due;
    return e;
  endfunction

  task automatic chk(string nm, logic [W-1:0] x, logic [W-1:0] y, exp_t e);
    n_vec++;
    if (x !== e.x || y !== e.y || cyc != e.due) begin
      n_err++;
      $display("FAIL %s: got x=%h y=%h at cycle %0d, need x=%h y=%h at cycle %0d",
               nm, x, y, cyc, e.x, e.y, e.due);
    end
  endtask

  task automatic fail_line(string nm, string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s at cycle %0d", nm, what, cyc);
  endtask

  // Monitor: pops one expectation per presented output and flags
  // outputs nobody asked for as well as expectations that came due unseen.
  always @(negedge clk) begin
    exp_t e;
    if (pv1) begin
      if (q_pg1.size() == 0) fail_line("dut1_pg", "unexpected pg_valid");
      else begin e = q_pg1.pop_front(); chk("dut1_pg", g1, p1, e); end
    end else if (q_pg1.size() != 0 && q_pg1[0].due <= cyc) begin
      void'(q_pg1.pop_front()); fail_line("dut1_pg", "missing pg_valid");
    end
    if (bv1) begin
      if (q_buf1.size() == 0) fail_line("dut1_buf", "unexpected buf_valid_out");
      else begin e = q_buf1.pop_front(); chk("dut1_buf", po1, go1, e); end
    end else if (q_buf1.size() != 0 && q_buf1[0].due <= cyc) begin
      void'(q_buf1.pop_front()); fail_line("dut1_buf", "missing buf_valid_out");
    end
    if (pv0) begin
      if (q_pg0.size() == 0) fail_line("dut0_pg", "unexpected pg_valid");
      else begin e = q_pg0.pop_front(); chk("dut0_pg", g0, p0, e); end
    end else if (q_pg0.size() != 0 && q_pg0[0].due <= cyc) begin
      void'(q_pg0.pop_front()); fail_line("dut0_pg", "missing pg_valid");
    end
    if (bv0) begin
      if (q_buf0.size() == 0) fail_line("dut0_buf", "unexpected buf_valid_out");
      else begin e = q_buf0.pop_front(); chk("dut0_buf", po0, go0, e); end
    end else if (q_buf0.size() != 0 && q_buf0[0].due <= cyc) begin
      void'(q_buf0.pop_front()); fail_line("dut0_buf", "missing buf_valid_out");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    buf_valid_in = 1'b0;
  endtask

  task automatic issue_pg(logic [W-1:0] va, logic [W-1:0] vb, logic vc,
                          logic [W-1:0] e1g, logic [W-1:0] e1p,
                          logic [W-1:0] e0g, logic [W-1:0] e0p);
    exp_t e;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    e.x = e1g; e.y = e1p; e.due = cyc + 1; q_pg1.push_back(e);
    e.x = e0g; e.y = e0p; e.due = cyc + 1; q_pg0.push_back(e);
  endtask

  task automatic issue_buf(logic [W-1:0] vp, logic [W-1:0] vg);
    exp_t e;
    pin = vp; gin = vg; buf_valid_in = 1'b1;
    e.x = vp; e.y = vg;
    e.due = cyc + 2; q_buf1.push_back(e);
    e.due = cyc + 1; q_buf0.push_back(e);
  endtask

  task automatic check_all_zero(string nm);
    n_vec++;
    if ({g1, p1, pv1, po1, go1, bv1, g0, p0, pv0, po0, go0, bv0} !== '0) begin
      n_err++;
      $display("FAIL %s: outputs not cleared (dut1 g=%h p=%h v=%b po=%h go=%h bv=%b; dut0 g=%h p=%h v=%b po=%h go=%h bv=%b), need all 0",
               nm, g1, p1, pv1, po1, go1, bv1, g0, p0, pv0, po0, go0, bv0);
    end
  endtask

  task automatic check_hold(string nm, logic [W-1:0] act, logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", nm, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, rp, rg;
    logic         rc;

    // Reset dominates valid inputs carrying all-ones.
    rst = 1'b1; in_valid = 1'b1; a = '1; b = '1; cin = 1'b1;
    buf_valid_in = 1'b1; pin = '1; gin = '1;
    @(posedge clk); @(negedge clk); check_all_zero("reset_c1");
    @(posedge clk); @(negedge clk); check_all_zero("reset_c2");
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; buf_valid_in = 1'b0;

    // Directed PG vectors: dut1 injects cin at bit 0, dut0 computes bit 0.
    issue_pg(32'h0000000F, 32'h00000005, 1'b1, 32'h00000005, 32'h0000000A, 32'h00000005, 32'h0000000A);
    tick();
    issue_pg(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000);
    tick();
    issue_pg(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001);
    tick();
    issue_pg(32'h00000002, 32'h00000002, 1'b1, 32'h00000003, 32'h00000000, 32'h00000002, 32'h00000000);
    tick();
    issue_pg(32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF);
    tick();
    issue_pg(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000);
    tick();
    a = 32'h12345678; b = 32'h0F0F0F0F; cin = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_hold("pg_hold_g1", g1, 32'hFFFFFFFF);
    check_hold("pg_hold_p1", p1, 32'h00000000);
    check_hold("pg_hold_g0", g0, 32'hFFFFFFFF);

    // Single buffer pulse, then confirm the outputs hold afterwards.
    tick();
    issue_buf(32'hA5A5A5A5, 32'h5A5A5A5A);
    tick();
    pin = 32'h11111111; gin = 32'h22222222;
    tick(); tick(); tick();
    @(negedge clk);
    check_hold("buf_hold_p1", po1, 32'hA5A5A5A5);
    check_hold("buf_hold_g1", go1, 32'h5A5A5A5A);
    check_hold("buf_hold_p0", po0, 32'hA5A5A5A5);
    check_hold("buf_hold_g0", go0, 32'h5A5A5A5A);

    // Back-to-back stream on both lanes.
    tick();
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      rp = $urandom; rg = $urandom;
      a = ra; b = rb; cin = rc; in_valid = 1'b1;
      q_pg1.push_back(pg_model(ra, rb, rc, 1'b1, cyc + 1));
      q_pg0.push_back(pg_model(ra, rb, rc, 1'b0, cyc + 1));
      issue_buf(rp, rg);
      tick();
    end
    tick(); tick(); tick();

    // Stream interrupted by reset; in-flight data must be discarded.
    for (int i = 0; i < 2; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc; in_valid = 1'b1;
      q_pg1.push_back(pg_model(ra, rb, rc, 1'b1, cyc + 1));
      q_pg0.push_back(pg_model(ra, rb, rc, 1'b0, cyc + 1));
      issue_buf($urandom, $urandom);
      tick();
    end
    rst = 1'b1;
    a = $urandom; b = $urandom; in_valid = 1'b1;
    pin = $urandom; gin = $urandom; buf_valid_in = 1'b1;
    tick();
    q_pg1.delete(); q_pg0.delete(); q_buf1.delete(); q_buf0.delete();
    rst = 1'b0;
    @(negedge clk); check_all_zero("midreset_clear");
    tick(); tick(); tick(); tick();
    @(negedge clk); check_all_zero("post_reset_idle");

    // First accepted input after reset: latency must be 1 / BUF_DEPTH.
    tick();
    issue_pg(32'h0000F00D, 32'h0000FF00, 1'b1, 32'h0000F001, 32'h00000F0C, 32'h0000F000, 32'h00000F0D);
    issue_buf(32'hCAFEBABE, 32'hDEADBEEF);
    tick(); tick(); tick(); tick();
    @(negedge clk);

    n_vec++;
    if (q_pg1.size() + q_pg0.size() + q_buf1.size() + q_buf0.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs never appeared, need 0",
               q_pg1.size() + q_pg0.size() + q_buf1.size() + q_buf0.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
